// File: rtl/bmem_pkg.sv
// bmem_pkg: shared types, beat geometry and helpers for burst_mem_responder
package bmem_pkg;
    typedef logic [31:0] rv32i_word;
    localparam int BURST_LEN = 4;
    localparam int BEAT_W = 64;
    typedef logic [BURST_LEN*BEAT_W-1:0] line_t;
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} bmem_state_e;
    function automatic logic [BEAT_W-1:0] beat_of(input line_t l, input logic [1:0] k);
        return l[BEAT_W*k +: BEAT_W];
    endfunction
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction
endpackage

// File: rtl/bmem_line_ram.sv
// bmem_line_ram: line-wide storage, combinational line read, 64-bit lane write
module bmem_line_ram
    import bmem_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       wr_beat,
    input  logic [BEAT_W-1:0] wr_data
);
    line_t mem [2**IDX_W];
    assign rd_line = mem[rd_idx];
    always_ff @(posedge clk)
        if (we) mem[wr_idx][BEAT_W*wr_beat +: BEAT_W] <= wr_data;
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 4-beat 256-bit line responder; BMEM_JITTER_EN adds LFSR wait jitter
module burst_mem_responder
    import bmem_pkg::*;
#(
    parameter int LINE_IDX_W = 7,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  rv32i_word   mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);
    localparam int CNT_W = $clog2(LATENCY + 8);
    bmem_state_e state;
    logic op_write;
    logic [26:0] line_addr;
    logic [CNT_W-1:0] lat_cnt;
    logic [1:0] beat;
    logic [2:0] jitter;
    logic req_bad;
    logic unused;
    line_t rd_line;
    assign unused = ^mem_addr[4:0];
    assign req_bad = (op_write ? !mem_write : !mem_read) || (mem_addr[31:5] != line_addr);
`ifdef BMEM_JITTER_EN
    logic [7:0] lfsr;
    assign jitter = lfsr[2:0];
    always_ff @(posedge clk)
        if (rst) lfsr <= 8'hA5;
        else if (state == IDLE && (mem_read || mem_write)) lfsr <= lfsr_next(lfsr);
`else
    assign jitter = 3'd0;
`endif
    bmem_line_ram #(.IDX_W(LINE_IDX_W)) u_ram (
        .clk    (clk),
        .rd_idx (line_addr[LINE_IDX_W-1:0]),
        .rd_line(rd_line),
        .we     (!rst && state == BURST && op_write),
        .wr_idx (line_addr[LINE_IDX_W-1:0]),
        .wr_beat(beat),
        .wr_data(mem_wdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mem_resp <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
            op_write <= 1'b0;
            line_addr <= '0;
            lat_cnt <= '0;
            beat <= '0;
        end else begin
            case (state)
                IDLE: if (mem_read || mem_write) begin
                    state <= WAIT;
                    op_write <= !mem_read;
                    line_addr <= mem_addr[31:5];
                    lat_cnt <= CNT_W'(LATENCY - 1) + CNT_W'(jitter);
                    if (mem_read && mem_write) proto_err <= 1'b1;
                end
                WAIT: begin
                    if (req_bad) proto_err <= 1'b1;
                    if (lat_cnt == '0) begin
                        state <= BURST;
                        mem_resp <= 1'b1;
                        beat <= 2'd0;
                        if (!op_write) mem_rdata <= beat_of(rd_line, 2'd0);
                    end else lat_cnt <= lat_cnt - 1'b1;
                end
                BURST: begin
                    if (req_bad) proto_err <= 1'b1;
                    if (beat == 2'd3) begin
                        state <= DONE;
                        mem_resp <= 1'b0;
                    end else begin
                        beat <= beat + 2'd1;
                        if (!op_write) mem_rdata <= beat_of(rd_line, beat + 2'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
